// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
// Buffers DAC codes from the converter in a small FIFO and writes one code to
// the 8-bit parallel DAC every SAMPLE_PERIOD clocks. Each write is a
// chip-select / write-strobe bus cycle. A tick that finds the FIFO empty is
// reported as an underflow.
//
// Optional build macro: DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN
//   When defined, an underflow also runs a full bus cycle that writes 8'h80,
//   which parks the DAC at midscale.
//   When undefined, an underflow performs no bus cycle and the DAC keeps the
//   last code written to it.
module dac_sample_scheduler #(
  parameter int         FIFO_DEPTH    = 8,
  parameter int         SAMPLE_PERIOD = 64,
  parameter int         WR_PULSE      = 2,
  parameter logic [7:0] RESET_CODE    = 8'h00,
  parameter int         UCNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          valid_in,
  input  logic [7:0]                    dac_code_in,
  output logic                          ready_out,
  output logic [7:0]                    dac_data,
  output logic                          dac_cs_n,
  output logic                          dac_wr_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow_pulse,
  output logic [UCNT_WIDTH-1:0]         underflow_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int TW  = $clog2(SAMPLE_PERIOD);
  localparam int SCW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(SAMPLE_PERIOD - 1);
  localparam logic [SCW-1:0] STROBE_LOAD  = SCW'(WR_PULSE - 1);
  localparam logic [LW-1:0]  FULL_LEVEL   = LW'(FIFO_DEPTH);
`ifdef DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN
  localparam logic [7:0]     MIDSCALE     = 8'h80;
`endif

  // The sample period must leave room for a complete bus cycle, so a tick
  // can only ever arrive while the FSM is idle.
  if (SAMPLE_PERIOD < WR_PULSE + 3) begin : g_bad_period
    $error("dac_sample_scheduler: SAMPLE_PERIOD must be >= WR_PULSE+3");
  end
  if (WR_PULSE < 1) begin : g_bad_pulse
    $error("dac_sample_scheduler: WR_PULSE must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dac_sample_scheduler: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state, state_next;
  logic [SCW-1:0]  strobe_cnt, strobe_cnt_next;
  logic [TW-1:0]   timer;
  logic            tick;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_next;
  logic            push, pop;

  logic [7:0]            dac_data_next;
  logic                  underflow_next;
  logic [UCNT_WIDTH-1:0] ucount_next;

  assign push       = valid_in && ready_out;
  assign tick       = enable && (timer == '0);
  assign fifo_level = level;

  // Sample-period timer: counts down while enabled, otherwise parks at the
  // reload value, so re-enabling always starts a full period.
  always_ff @(posedge clk) begin
    if (reset || !enable || (timer == '0)) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  // FIFO storage. Flushing is done through the pointers, so the array
  // contents do not need a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dac_code_in;
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ready_out <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level     <= level_next;
      ready_out <= (level_next != FULL_LEVEL);
    end
  end

  // Bus-cycle sequencing: next state, FIFO pop, data latch and underflow
  // accounting.
  always_comb begin
    state_next      = state;
    strobe_cnt_next = strobe_cnt;
    dac_data_next   = dac_data;
    pop             = 1'b0;
    underflow_next  = 1'b0;
    ucount_next     = underflow_count;
    case (state)
      IDLE: begin
        if (tick) begin
          if (level != '0) begin
            pop           = 1'b1;
            dac_data_next = mem[rd_ptr];
            state_next    = SETUP;
          end else begin
            underflow_next = 1'b1;
            if (underflow_count != '1) begin
              ucount_next = underflow_count + 1'b1;
            end
`ifdef DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN
            dac_data_next = MIDSCALE;
            state_next    = SETUP;
`endif
          end
        end
      end
      SETUP: begin
        state_next      = STROBE;
        strobe_cnt_next = STROBE_LOAD;
      end
      STROBE: begin
        if (strobe_cnt == '0) begin
          state_next = HOLD;
        end else begin
          strobe_cnt_next = strobe_cnt - 1'b1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered bus outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      strobe_cnt      <= '0;
      dac_data        <= RESET_CODE;
      dac_cs_n        <= 1'b1;
      dac_wr_n        <= 1'b1;
      busy            <= 1'b0;
      underflow_pulse <= 1'b0;
      underflow_count <= '0;
    end else begin
      state           <= state_next;
      strobe_cnt      <= strobe_cnt_next;
      dac_data        <= dac_data_next;
      dac_cs_n        <= (state_next == IDLE);
      dac_wr_n        <= (state_next != STROBE);
      busy            <= (state_next != IDLE);
      underflow_pulse <= underflow_next;
      underflow_count <= ucount_next;
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler with FIFO_DEPTH=4, SAMPLE_PERIOD=8 and
// WR_PULSE=2. Stimulus queues the expected DAC codes. A negedge monitor
// checks the shape of every bus cycle and pops the expected code on each
// write-strobe fall. Honours DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN.
module tb_dac_sample_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       valid_in;
  logic [7:0] dac_code_in;
  logic       ready_out;
  logic [7:0] dac_data;
  logic       dac_cs_n;
  logic       dac_wr_n;
  logic       busy;
  logic [2:0] fifo_level;
  logic       underflow_pulse;
  logic [15:0] underflow_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] exp_q [$];
  int         wr_times [$];
  int         bus_cycles = 0;
  int         uf_seen    = 0;

  logic       prev_cs = 1'b1;
  logic       prev_wr = 1'b1;
  logic       prev_up = 1'b0;
  logic       in_cs   = 1'b0;
  logic       pending_mid = 1'b0;
  logic       data_moved  = 1'b0;
  logic [7:0] cs_data = 8'h00;
  int         cs_len  = 0;
  int         wr_len  = 0;

  dac_sample_scheduler #(
    .FIFO_DEPTH   (4),
    .SAMPLE_PERIOD(8),
    .WR_PULSE     (2),
    .RESET_CODE   (8'h00),
    .UCNT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .valid_in       (valid_in),
    .dac_code_in    (dac_code_in),
    .ready_out      (ready_out),
    .dac_data       (dac_data),
    .dac_cs_n       (dac_cs_n),
    .dac_wr_n       (dac_wr_n),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .underflow_pulse(underflow_pulse),
    .underflow_count(underflow_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Free-running cycle counter used to time bus cycles
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Push one code for one cycle; accepted codes are queued as expected output
  task automatic applyStimulus(input logic [7:0] code, input bit accept);
    valid_in    = 1'b1;
    dac_code_in = code;
    if (accept) exp_q.push_back(code);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    enable   = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: checks bus-cycle shape and scores each written code
  always @(negedge clk) begin
    if (reset) begin
      in_cs       = 1'b0;
      pending_mid = 1'b0;
      prev_cs     = 1'b1;
      prev_wr     = 1'b1;
      prev_up     = 1'b0;
    end else begin
      if (underflow_pulse) begin
        uf_seen++;
        checkOutput("uf_pulse_single", int'(prev_up), 0);
`ifdef DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN
        pending_mid = 1'b1;
`endif
      end
      if (!dac_cs_n && prev_cs) begin
        in_cs      = 1'b1;
        cs_len     = 0;
        wr_len     = 0;
        data_moved = 1'b0;
        cs_data    = dac_data;
        bus_cycles++;
        checkOutput("busy_in_cycle", int'(busy), 1);
      end
      if (!dac_cs_n) begin
        cs_len++;
        if (dac_data !== cs_data) data_moved = 1'b1;
      end
      if (!dac_wr_n) wr_len++;
      if (!dac_wr_n && prev_wr) begin
        checkOutput("wr_lead", cs_len, 2);
        wr_times.push_back(cyc);
        if (pending_mid) begin
          pending_mid = 1'b0;
          checkOutput("midscale_code", int'(dac_data), 'h80);
        end else begin
          checkOutput("pending_expect", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) checkOutput("dac_code", int'(dac_data), int'(exp_q.pop_front()));
        end
      end
      if (dac_cs_n && !prev_cs && in_cs) begin
        in_cs = 1'b0;
        checkOutput("cs_low_len", cs_len, 4);
        checkOutput("wr_low_len", wr_len, 2);
        checkOutput("data_stable", int'(data_moved), 0);
      end
      prev_cs = dac_cs_n;
      prev_wr = dac_wr_n;
      prev_up = underflow_pulse;
    end
  end

  int bc0;
  int uf0;
  int en_cyc;
  bit found;

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    valid_in    = 1'b0;
    dac_code_in = 8'h00;

    // Reset values
    doReset();
    checkOutput("rst_level", int'(fifo_level), 0);
    checkOutput("rst_ready", int'(ready_out), 1);
    checkOutput("rst_data", int'(dac_data), 0);
    checkOutput("rst_cs_n", int'(dac_cs_n), 1);
    checkOutput("rst_wr_n", int'(dac_wr_n), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_uf_pulse", int'(underflow_pulse), 0);
    checkOutput("rst_uf_count", int'(underflow_count), 0);

    // Idle with enable low: data buffered but never written
    applyStimulus(8'h11, 1'b1);
    checkOutput("idle_level", int'(fifo_level), 1);
    bc0 = bus_cycles;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("idle_no_bus", bus_cycles - bc0, 0);
    checkOutput("idle_cs_n", int'(dac_cs_n), 1);
    checkOutput("idle_data", int'(dac_data), 0);

    // Three writes 8 cycles apart, then one underflow
    doReset();
    wr_times.delete();
    bc0 = bus_cycles;
    uf0 = uf_seen;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    enable = 1'b1;
    en_cyc = cyc;
    repeat (36) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`ifdef DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN
    checkOutput("seq_bus_count", bus_cycles - bc0, 4);
    checkOutput("seq_final_data", int'(dac_data), 'h80);
`else
    checkOutput("seq_bus_count", bus_cycles - bc0, 3);
    checkOutput("seq_final_data", int'(dac_data), 'h33);
`endif
    if (wr_times.size() >= 3) begin
      checkOutput("seq_first_latency", wr_times[0] - en_cyc, 9);
      checkOutput("seq_spacing_1", wr_times[1] - wr_times[0], 8);
      checkOutput("seq_spacing_2", wr_times[2] - wr_times[1], 8);
    end else begin
      checkOutput("seq_wr_events", wr_times.size(), 3);
    end
    checkOutput("seq_uf_pulses", uf_seen - uf0, 1);
    checkOutput("seq_uf_count", int'(underflow_count), 1);
    checkOutput("seq_exp_drained", exp_q.size(), 0);

    // Overfill: fifth back-to-back code is dropped
    doReset();
    bc0 = bus_cycles;
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hA2, 1'b1);
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'hA4, 1'b1);
    checkOutput("full_ready", int'(ready_out), 0);
    checkOutput("full_level", int'(fifo_level), 4);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("full_level_after_drop", int'(fifo_level), 4);
    enable = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("full_bus_count", bus_cycles - bc0, 4);
    checkOutput("full_exp_drained", exp_q.size(), 0);
    checkOutput("full_uf_count", int'(underflow_count), 0);
    checkOutput("full_ready_after", int'(ready_out), 1);

    // Streaming 20 codes through a depth-4 FIFO wraps the pointers
    doReset();
    bc0 = bus_cycles;
    applyStimulus(8'h40, 1'b1);
    applyStimulus(8'h41, 1'b1);
    enable = 1'b1;
    for (int i = 2; i < 20; i++) begin
      applyStimulus(8'h40 + 8'(i), 1'b1);
      repeat (7) @(posedge clk);
      #1;
    end
    repeat (16) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("stream_bus_count", bus_cycles - bc0, 20);
    checkOutput("stream_exp_drained", exp_q.size(), 0);
    checkOutput("stream_uf_count", int'(underflow_count), 0);
    checkOutput("stream_level", int'(fifo_level), 0);
    checkOutput("stream_last_data", int'(dac_data), 'h53);

    // Reset during the write strobe aborts the cycle and flushes the FIFO
    doReset();
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h6B, 1'b1);
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!dac_wr_n) found = 1'b1;
    end
    checkOutput("abort_wr_seen", int'(dac_wr_n), 0);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_cs_n", int'(dac_cs_n), 1);
    checkOutput("abort_wr_n", int'(dac_wr_n), 1);
    checkOutput("abort_data", int'(dac_data), 0);
    checkOutput("abort_level", int'(fifo_level), 0);
    checkOutput("abort_ready", int'(ready_out), 1);
    checkOutput("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sits between the fixed-point-to-DAC converter and the board's 8-bit parallel DAC pins.
- Buffers converted DAC codes in a small FIFO.
- Releases one code per programmable sample period.
- Sequences the DAC's chip-select/write-strobe bus cycle so the output update rate is fixed and independent of upstream valid timing.
- Reports underflows.

Parameters:
- FIFO_DEPTH, 8: number of buffered DAC codes; power of 2, >= 2.
- SAMPLE_PERIOD, 64: clk cycles between DAC updates; must be >= WR_PULSE+3, otherwise elaboration error.
- WR_PULSE, 2: cycles dac_wr_n is held low; >= 1.
- RESET_CODE, 8'h00: dac_data value after reset.
- UCNT_WIDTH, 16: width of the underflow counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run sample-period timer; 0 = no new DAC writes
- valid_in  in  1  dac_code_in valid
- dac_code_in  in  8  DAC code from converter
- ready_out  out  1  FIFO can accept (= not full)
- dac_data  out  8  DAC parallel data bus
- dac_cs_n  out  1  DAC chip select, active low
- dac_wr_n  out  1  DAC write strobe, active low
- busy  out  1  bus cycle in progress (FSM not IDLE)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- underflow_pulse  out  1  one-cycle pulse: tick found FIFO empty
- underflow_count  out  UCNT_WIDTH  saturating underflow count

Behaviour:
- Single clock domain; all registers reset synchronously when reset=1.
- Reset values:
  - FIFO empty, fifo_level=0, ready_out=1
  - dac_data=RESET_CODE, dac_cs_n=1, dac_wr_n=1, busy=0
  - underflow_pulse=0, underflow_count=0
  - timer=SAMPLE_PERIOD-1, FSM=IDLE
- Reset asserted mid-sequence aborts the sequence immediately: strobes return high next edge, FIFO is flushed.
- FIFO:
  - Push when valid_in && ready_out. valid_in while full is dropped; no state change.
  - Push and pop in the same cycle leaves fifo_level unchanged.
  - Pop occurs only from the FSM in IDLE on a tick.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO accepts data regardless of enable.
- Timer:
  - While enable=1, decrements each cycle. At 0 it asserts internal tick for one cycle and reloads SAMPLE_PERIOD-1.
  - While enable=0, holds at SAMPLE_PERIOD-1 and produces no tick.
  - Tick period is exactly SAMPLE_PERIOD cycles.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - cs_n=1, wr_n=1.
  - On tick with fifo_level>0: pop head into dac_data, go SETUP.
  - On tick with FIFO empty: underflow_pulse=1 next cycle, underflow_count+1 (saturating at all-ones), dac_data unchanged, stay IDLE.
- SETUP: cs_n=0, wr_n=1 for 1 cycle -> STROBE.
- STROBE: cs_n=0, wr_n=0 for WR_PULSE cycles (internal counter) -> HOLD.
- HOLD: cs_n=0, wr_n=1 for 1 cycle -> IDLE.
- Timing for a tick at cycle T (as seen by the FSM in IDLE):
  - dac_data valid from T+1.
  - cs_n low T+1..T+WR_PULSE+2.
  - wr_n low T+2..T+WR_PULSE+1.
- dac_data is stable throughout cs_n low; it changes only on the IDLE->SETUP transition.
- enable dropped mid-sequence: the current sequence completes and no further ticks occur. Re-enabling restarts the full period.
- The SAMPLE_PERIOD constraint guarantees a tick never arrives outside IDLE; no tick queuing.
- busy = (state != IDLE).
- All outputs are registered.

Optional Feature:
- Macro: DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN.
- Defined: a tick with FIFO empty still pulses and counts underflow, but also runs a full SETUP/STROBE/HOLD cycle writing 8'h80 to dac_data, so the DAC parks at midscale.
- Undefined: an underflow performs no bus cycle and dac_data holds the last written code.

Test Plan:
Common settings: FIFO_DEPTH=4, SAMPLE_PERIOD=8, WR_PULSE=2, RESET_CODE=8'h00.
- Reset then idle with enable=0, push 8'h11 -> fifo_level=1; no cs_n/wr_n activity for 50 cycles; dac_data=8'h00.
- Push 8'h11,8'h22,8'h33, enable=1 -> three bus cycles exactly 8 cycles apart.
  - dac_data 11/22/33.
  - Each cycle: cs_n low 4 cycles, wr_n low 2 cycles inside it.
  - Fourth tick: underflow_pulse once, underflow_count=1, dac_data stays 8'h33.
- Push 5 codes back-to-back with enable=0 -> ready_out low after the 4th push, 5th code dropped, fifo_level=4. Enabling outputs only the first 4 codes, in order.
- Continuous push of one code every 8 cycles while draining, running over 20 samples -> pointers wrap, all codes output in order, underflow_count=0.
- Assert reset during STROBE (wr_n=0) -> next cycle cs_n=1, wr_n=1, dac_data=8'h00, fifo_level=0, ready_out=1.
- With DAC_SCHED_MIDSCALE_ON_UNDERFLOW_EN defined, tick on empty FIFO -> bus cycle with dac_data=8'h80, underflow_count increments.
